// File: rtl/keypad_pkg.sv
// Keypad definitions shared by the number-entry datapath: keycodes, entry FSM
// states and the accumulator sizing helper.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_SIGN  = 4'hD;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } entry_state_t;

    // Bits needed to hold 10^nd - 1 without wrapping.
    function automatic int acc_width(input int nd);
        longint p;
        p = 64'd1;
        for (int i = 0; i < nd; i++) begin
            p = p * 64'd10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/bcd_horner_step.sv
// One Horner step of BCD-to-binary conversion: acc_o = acc_i * 10 + digit_i.
module bcd_horner_step #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [ACC_W-1:0] acc_o
);

    // x*10 = x*8 + x*2; the caller sizes ACC_W so the true result never wraps.
    assign acc_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad multi-digit signed number entry: BCD buffer with edit keys, then a
// digit-serial conversion to a saturated two's-complement value on valid/ready.
module digit_entry_buffer
    import keypad_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int VAL_W   = 12,
    parameter int CNT_W   = $clog2(NDIGITS + 1)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   keystrobe,
    input  logic [3:0]             keycode,
    output logic                   isdig,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [CNT_W-1:0]       count,
    output logic                   neg,
    output logic                   busy,
    output logic [VAL_W-1:0]       value,
    output logic                   ovf,
    output logic                   value_valid,
    input  logic                   value_ready
);

    localparam int               ACC_W = acc_width(NDIGITS);
    localparam int               MAG_W = ((ACC_W > VAL_W) ? ACC_W : VAL_W) + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(NDIGITS);

    entry_state_t         state_q, state_d;
    logic [4*NDIGITS-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 neg_q, neg_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic                 last_q, last_d;
    logic [VAL_W-1:0]     value_q, value_d;
    logic                 ovf_q, ovf_d;

    logic [3:0]           digit_sel;
    logic [ACC_W-1:0]     acc_step;

    // Returns {ovf, value}. Negative side may reach -2^(VAL_W-1); positive
    // side stops at 2^(VAL_W-1)-1. A zero magnitude stays zero when negated.
    function automatic logic [VAL_W:0] saturate(input logic [ACC_W-1:0] mag,
                                                input logic             sgn);
        logic [MAG_W-1:0]        mag_w;
        logic [MAG_W-1:0]        lim;
        logic signed [VAL_W-1:0] res;
        logic                    sat;
        mag_w          = MAG_W'(mag);
        lim            = '0;
        lim[VAL_W-1]   = 1'b1;
        if (!sgn) begin
            lim = lim - MAG_W'(1);
        end
        sat = (mag_w > lim);
        res = sat ? lim[VAL_W-1:0] : mag_w[VAL_W-1:0];
        if (sgn) begin
            res = -res;
        end
        return {sat, res};
    endfunction

    assign isdig = keystrobe && (keycode < 4'd10);

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == CNT_W'(i)) begin
                digit_sel = digits_q[4*i +: 4];
            end
        end
    end

    bcd_horner_step #(
        .ACC_W (ACC_W)
    ) u_horner (
        .acc_i   (acc_q),
        .digit_i (digit_sel),
        .acc_o   (acc_step)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ENTRY;
            digits_q <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            value_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            value_q  <= value_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        last_d   = last_q;
        value_d  = value_q;
        ovf_d    = ovf_q;

        case (state_q)
            ENTRY: begin
                if (keystrobe) begin
                    if (isdig) begin
                        if (count_q < FULL) begin
                            for (int i = NDIGITS - 1; i > 0; i--) begin
                                digits_d[4*i +: 4] = digits_q[4*(i-1) +: 4];
                            end
                            digits_d[3:0] = keycode;
                            count_d       = count_q + CNT_W'(1);
                        end
                    end else begin
                        case (keycode)
                            KEY_ENTER: begin
                                if (count_q != '0) begin
                                    acc_d   = '0;
                                    idx_d   = count_q - CNT_W'(1);
                                    last_d  = 1'b0;
                                    state_d = CONVERT;
                                end
                            end
                            KEY_BKSP: begin
                                if (count_q != '0) begin
                                    for (int i = 0; i < NDIGITS - 1; i++) begin
                                        digits_d[4*i +: 4] = digits_q[4*(i+1) +: 4];
                                    end
                                    digits_d[4*NDIGITS-1 -: 4] = 4'd0;
                                    count_d = count_q - CNT_W'(1);
                                end
                            end
                            KEY_CLR: begin
                                digits_d = '0;
                                count_d  = '0;
                                neg_d    = 1'b0;
                            end
                            KEY_SIGN: begin
                                neg_d = ~neg_q;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // After the last digit is folded in, one extra cycle applies the
            // sign and saturation so the limit compare sits off the adder path.
            CONVERT: begin
                if (last_q) begin
                    {ovf_d, value_d} = saturate(acc_q, neg_q);
                    state_d          = HOLD;
                end else begin
                    acc_d = acc_step;
                    if (idx_q == '0) begin
                        last_d = 1'b1;
                    end else begin
                        idx_d = idx_q - CNT_W'(1);
                    end
                end
            end

            HOLD: begin
                if (value_ready) begin
                    digits_d = '0;
                    count_d  = '0;
                    neg_d    = 1'b0;
                    state_d  = ENTRY;
                end
            end

            default: state_d = ENTRY;
        endcase
    end

    assign digits      = digits_q;
    assign count       = count_q;
    assign neg         = neg_q;
    assign busy        = (state_q != ENTRY);
    assign value       = value_q;
    assign ovf         = ovf_q;
    assign value_valid = (state_q == HOLD);

endmodule

// File: doc/digit_entry_buffer.md
# digit_entry_buffer

Parametrised keypad number-entry block: accepts single-cycle keystrobes carrying 4-bit keycodes, shifts decimal digits into an NDIGITS-deep BCD buffer, supports backspace, clear and sign toggle, and on Enter converts the buffer to a signed binary value over several cycles. The result is offered downstream on a valid/ready handshake to the matrix-element loader. It replaces single-digit capture wherever multi-digit signed operands are entered.

## Interface
- NDIGITS, 3: maximum decimal digits held (1..8)
- VAL_W, 12: width of signed binary result (two's complement)
- CNT_W, $clog2(NDIGITS+1): width of digit count (derived)
- clk  input  1  system clock, all state on rising edge
- nrst  input  1  reset; one clock; reset is asynchronous and active-low
- keystrobe  input  1  one-cycle pulse, keycode valid
- keycode  input  4  0-9 digit, A Enter, B Backspace, C Clear, D Sign toggle, E/F ignored
- isdig  output  1  combinational: keystrobe && keycode < 10, any state
- digits  output  4*NDIGITS  BCD buffer, digit 0 (least significant) in bits [3:0]
- count  output  CNT_W  digits currently held
- neg  output  1  sign flag for display
- busy  output  1  high in CONVERT or HOLD
- value  output  VAL_W  signed result, stable while value_valid
- ovf  output  1  result saturated; qualified by value_valid
- value_valid  output  1  result available
- value_ready  input  1  downstream accepts result

## Operation
- States: ENTRY, CONVERT, HOLD. Reset: ENTRY, digits=0, count=0, neg=0, value=0, ovf=0, value_valid=0, busy=0.
- ENTRY, digit key: if count<NDIGITS, digits <= {digits[.. -1 digit], key}, count+1; if full, key dropped, no state change.
- ENTRY, Backspace: if count>0, shift right one digit (top digit zero-filled), count-1; else no-op.
- ENTRY, Clear: digits=0, count=0, neg=0.
- ENTRY, Sign toggle: neg <= ~neg (allowed at any count).
- ENTRY, Enter: if count==0, ignored; else load accumulator=0, index=count-1, go CONVERT.
- CONVERT: one digit per cycle, most significant first: acc <= acc*10 + digits[index]; after index 0 processed, go HOLD.
- Accumulator is unsigned, width wide enough for 10^NDIGITS-1 (no internal wrap).
- HOLD entry: magnitude limit = 2^(VAL_W-1) for neg, 2^(VAL_W-1)-1 otherwise; if acc exceeds limit, value = limit with sign applied, ovf=1; else value = neg ? -acc : acc, ovf=0. value_valid=1.
- HOLD: value_valid && value_ready -> clear digits, count, neg, value_valid; go ENTRY.
- All keystrobes in CONVERT/HOLD ignored (isdig still reflects them); Clear does not abort.
- -0 yields value 0, ovf 0.

## Timing
- Keystroke effect on digits/count/neg visible the cycle after the strobe edge.
- Enter sampled at edge t with count=n: CONVERT for edges t+1..t+n, value_valid high after edge t+n+1 (latency n+1 cycles).
- value, ovf registered; unchanged while value_valid high.
- value_ready may be high before value_valid; transfer occurs on first edge both high; value_valid low the following cycle; new keystrobe accepted that same cycle.
- nrst assertion mid-CONVERT or HOLD returns immediately to reset values; no partial result emitted.
- isdig is purely combinational, zero latency.

## Structure
- Shared package keypad_pkg: keycode constants KEY_ENTER=4'hA, KEY_BKSP=4'hB, KEY_CLR=4'hC, KEY_SIGN=4'hD; entry_state_t enum {ENTRY, CONVERT, HOLD}.
- One sub-module natural: bcd_horner_step (combinational acc*10+digit, parametrised width), instantiated once.
- Buffer, count, sign and FSM in top-level.

## Test plan
- Reset, then keys 1,2,3, Enter with value_ready=1 -> value_valid 4 cycles after Enter, value=123, ovf=0; buffer cleared next cycle.
- Keys 4,5,Sign,Enter -> value=-45 (12'hFD3), ovf=0.
- Keys 9,9,9,9 (4th dropped, count=3), Backspace, 7, Enter -> value=997.
- VAL_W=8: keys 2,0,0,Enter -> value=127, ovf=1; with Sign -> value=-128, ovf=1; 1,2,8,Sign -> -128, ovf=0.
- Enter with count=0 -> stays ENTRY, busy=0; digit strobes during HOLD with value_ready=0 -> ignored, isdig pulses, value stable until ready.
- nrst pulsed during CONVERT -> all outputs at reset values, no value_valid afterwards.
